// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: instruction/PC widths and the fetch entry
// carried through the fetch queue.
package riscv_pkg;

    localparam int INST_WIDTH = 32;
    localparam int PC_WIDTH   = 32;

    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [INST_WIDTH-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-queue handshake bundle. The master side is fetch plus decoder, the
// slave side is the queue itself.
interface fetch_queue_if
    import riscv_pkg::*;
#(
    parameter int DEPTH = 8
);

    logic                   enq_ready;
    logic                   enq0_valid;
    fetch_entry_t           enq0;
    logic                   enq1_valid;
    fetch_entry_t           enq1;

    logic                   deq0_valid;
    fetch_entry_t           deq0;
    logic                   deq1_valid;
    fetch_entry_t           deq1;
    logic                   deq0_take;
    logic                   deq1_take;

    logic [$clog2(DEPTH):0] count;

    modport slave (
        input  enq0_valid, enq0, enq1_valid, enq1, deq0_take, deq1_take,
        output enq_ready, deq0_valid, deq0, deq1_valid, deq1, count
    );

    modport master (
        output enq0_valid, enq0, enq1_valid, enq1, deq0_take, deq1_take,
        input  enq_ready, deq0_valid, deq0, deq1_valid, deq1, count
    );

endinterface

// File: rtl/fetch_queue_ptr.sv
// Wrapping circular-buffer pointer: advances by 0, 1 or 2 per cycle and wraps
// naturally at the power-of-two depth; clear returns it to entry 0.
module fetch_queue_ptr #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic [1:0]    adv,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] ptr_reg;

    // Pointer register; modulo wrap comes from the AW-bit width.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_reg + AW'(adv);
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/fetch_queue.sv
// Two-wide in-order fetch queue between instruction fetch and decode.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN -- when defined and the queue
// is empty, enqueued slots are presented on deq0/deq1 in the same cycle.
// Data widths come from riscv_pkg; DEPTH must be a power of two, >= 4.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    fetch_queue_if.slave    fq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [AW-1:0]   head1;
    logic [AW-1:0]   tail1;
    logic            enq_ready;
    logic            fire_enq0;
    logic            fire_enq1;
    logic            valid0;
    logic            valid1;
    logic            take0;
    logic            take1;
    logic [1:0]      n_enq;
    logic [1:0]      n_deq;
    logic [DEPTH-1:0] we0;
    logic [DEPTH-1:0] we1;

    assign head1 = head + AW'(1);
    assign tail1 = tail + AW'(1);

    // Space is judged on registered occupancy only, so a dequeue in the same
    // cycle never opens room for a bundle.
    assign enq_ready = (count_reg <= CW'(DEPTH - 2));
    assign fire_enq0 = enq_ready && fq.enq0_valid && !flush;
    assign fire_enq1 = fire_enq0 && fq.enq1_valid;
    assign n_enq     = 2'(fire_enq0) + 2'(fire_enq1);

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass  = (count_reg == '0) && !flush;
    assign valid0  = (count_reg >= CW'(1)) || (bypass && fq.enq0_valid);
    assign valid1  = (count_reg >= CW'(2)) || (bypass && fq.enq0_valid && fq.enq1_valid);
    // Bypassed entries are still written at tail; head advancing over the
    // taken ones makes them invisible, so no separate write suppression.
    assign fq.deq0 = (count_reg == '0) ? fq.enq0 : mem[head];
    assign fq.deq1 = (count_reg == '0) ? fq.enq1 : mem[head1];
`else
    assign valid0  = (count_reg >= CW'(1));
    assign valid1  = (count_reg >= CW'(2));
    assign fq.deq0 = mem[head];
    assign fq.deq1 = mem[head1];
`endif

    // Slot 1 is only consumed together with slot 0; flush discards takes.
    assign take0 = fq.deq0_take && valid0 && !flush;
    assign take1 = take0 && fq.deq1_take && valid1;
    assign n_deq = 2'(take0) + 2'(take1);

    assign count_next = count_reg + CW'(n_enq) - CW'(n_deq);

    // Occupancy counter; flush empties the queue exactly like reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    fetch_queue_ptr #(.AW(AW)) u_head (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .adv   (n_deq),
        .ptr   (head)
    );

    fetch_queue_ptr #(.AW(AW)) u_tail (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .adv   (n_enq),
        .ptr   (tail)
    );

    // Per-entry write enables; a bundle may straddle the wrap point.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
        assign we0[gi] = fire_enq0 && (tail  == AW'(gi));
        assign we1[gi] = fire_enq1 && (tail1 == AW'(gi));
    end

    // Storage array, not reset; entries are meaningful only below count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we0[i]) begin
                mem[i] <= fq.enq0;
            end else if (we1[i]) begin
                mem[i] <= fq.enq1;
            end
        end
    end

    assign fq.enq_ready  = enq_ready;
    assign fq.deq0_valid = valid0;
    assign fq.deq1_valid = valid1;
    assign fq.count      = count_reg;

    // Slot 1 without slot 0 is illegal on either side of the queue.
    a_deq_order: assert property (@(posedge clk) disable iff (rst)
        !(fq.deq1_take && !fq.deq0_take));
    a_enq_order: assert property (@(posedge clk) disable iff (rst)
        !(fq.enq1_valid && !fq.enq0_valid));

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue (DEPTH = 8): the driver pushes accepted
// entries, a negedge monitor pops and compares every entry the decoder takes.
module tb_fetch_queue;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(8)) fq ();

    fetch_queue #(.DEPTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .fq    (fq)
    );

    int total = 0;
    int bad   = 0;
    int mcount = 0;
    fetch_entry_t sb[$];

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs, predict, check status mid-cycle, update model.
    task automatic step(input bit e0v, input bit e1v,
                        input logic [31:0] pc0, input logic [31:0] i0,
                        input logic [31:0] pc1, input logic [31:0] i1,
                        input bit t0, input bit t1, input bit fl);
        bit byp, v0, v1, acc;
        int ne, nd;
        fq.enq0_valid = e0v;
        fq.enq1_valid = e1v;
        fq.enq0       = '{pc: pc0, inst: i0};
        fq.enq1       = '{pc: pc1, inst: i1};
        fq.deq0_take  = t0;
        fq.deq1_take  = t1;
        flush         = fl;
        byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (mcount == 0) && !fl;
`endif
        v0  = (mcount >= 1) || (byp && e0v);
        v1  = (mcount >= 2) || (byp && e0v && e1v);
        acc = (mcount <= 6) && e0v && !fl;
        if (acc) begin
            sb.push_back('{pc: pc0, inst: i0});
            if (e1v) sb.push_back('{pc: pc1, inst: i1});
        end
        ne = acc ? (e1v ? 2 : 1) : 0;
        nd = fl ? 0 : ((t0 && v0) ? ((t1 && v1) ? 2 : 1) : 0);
        @(negedge clk);
        chk("count",      fq.count,      mcount);
        chk("enq_ready",  fq.enq_ready,  (mcount <= 6));
        chk("deq0_valid", fq.deq0_valid, v0);
        chk("deq1_valid", fq.deq1_valid, v1);
        $display("cycle e=%0d%0d t=%0d%0d fl=%0d count=%0d", e0v, e1v, t0, t1, fl, fq.count);
        @(posedge clk);
        #1;
        mcount = fl ? 0 : mcount + ne - nd;
        if (fl) sb.delete();
    endtask

    task automatic idle(input bit t0, input bit t1, input bit fl);
        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, t0, t1, fl);
    endtask

    task automatic bundle(input logic [31:0] pc, input bit t0, input bit t1, input bit fl);
        step(1'b1, 1'b1, pc, ins(pc), pc + 32'h4, ins(pc + 32'h4), t0, t1, fl);
    endtask

    // Monitor: every entry the decoder takes must be the oldest expected one.
    always @(negedge clk) begin
        if (!rst && fq.deq0_valid && fq.deq0_take) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL deq0_unexpected actual=%0h required=none", fq.deq0.pc);
            end else begin
                chk("deq0_pc",   fq.deq0.pc,   sb[0].pc);
                chk("deq0_inst", fq.deq0.inst, sb[0].inst);
                void'(sb.pop_front());
            end
            if (fq.deq1_valid && fq.deq1_take) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL deq1_unexpected actual=%0h required=none", fq.deq1.pc);
                end else begin
                    chk("deq1_pc",   fq.deq1.pc,   sb[0].pc);
                    chk("deq1_inst", fq.deq1.inst, sb[0].inst);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] p;
        rst = 1'b1;
        flush = 1'b0;
        fq.enq0_valid = 1'b0;
        fq.enq1_valid = 1'b0;
        fq.enq0 = '0;
        fq.enq1 = '0;
        fq.deq0_take = 1'b0;
        fq.deq1_take = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mcount = 0;

        // Reset state, then first bundle and its one-cycle latency.
        idle(0, 0, 0);
        step(1'b1, 1'b1, 32'h100, 32'h0000_0013, 32'h104, 32'h0010_0093, 0, 0, 0);
        idle(1, 1, 0);

        // Fill to 8; further bundles refused.
        p = 32'h1000;
        for (int b = 0; b < 4; b++) begin
            bundle(p, 0, 0, 0);
            p += 32'h8;
        end
        bundle(p, 0, 0, 0);
        bundle(p, 1, 0, 0);
        // count = 7: take one, bundle still refused.
        bundle(p, 1, 0, 0);
        idle(0, 0, 0);

        // Sustained 2-in/2-out across the pointer wrap at count = 6.
        p = 32'h2000;
        for (int c = 0; c < 20; c++) begin
            bundle(p, 1, 1, 0);
            p += 32'h8;
        end

        // count = 5, then flush with enqueue and take in the same cycle.
        idle(1, 0, 0);
        bundle(32'h2800, 1, 1, 1);
        idle(0, 0, 0);

        // Single-slot enqueue after flush, then take it.
        step(1'b1, 1'b0, 32'h3000, ins(32'h3000), 32'h0, 32'h0, 0, 0, 0);
        idle(1, 1, 0);

        // Enqueue into empty queue with deq0_take only.
        bundle(32'h200, 1, 0, 0);
        idle(1, 0, 0);
        idle(1, 1, 0);
        idle(0, 0, 0);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
